keypad_emulator: RTL

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/keypad_emulator.sv
// keypad_emulator: replays queued key codes onto an active-low row/column keypad matrix.
//
// Codes pushed on in_code/in_valid go into a 4-entry FIFO. Each code is pressed for
// HOLD_CYCLES cycles and then released for GAP_CYCLES cycles. One more idle cycle follows
// before the next code is popped.
//
// Ports:
//   clock      - sole clock, rising edge
//   resetn     - asynchronous active-low reset
//   col[3:0]   - column drive from the scanner, active-low
//   row[3:0]   - row sense back to the scanner, active-low (1 = released)
//   in_code    - key to emulate: [3:2] row index, [1:0] column index
//   in_valid   - in_code valid this cycle
//   in_ready   - FIFO can accept a code this cycle
//   active     - an emulated key is currently asserted in the matrix
//   fifo_count - number of queued codes, 0-4
//
// Build option: define KEYPAD_BOUNCE_EN to put a 4-cycle bounce (active 1,0,1,0) in front of
// every press. The steady HOLD_CYCLES phase follows the bounce.

module keypad_emulator #(
  parameter int unsigned HOLD_CYCLES = 8,
  parameter int unsigned GAP_CYCLES  = 8
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic [3:0] in_code,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       active,
  output logic [2:0] fifo_count
);

  localparam logic [7:0] HoldLoad = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GapLoad  = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPress, StGap} state_e;

  state_e     state_q;
  logic [3:0] mem_q [4];
  logic [1:0] wr_ptr_q;
  logic [1:0] rd_ptr_q;
  logic [2:0] count_q;
  logic [2:0] count_d;
  logic       ready_q;
  logic [3:0] key_q;
  logic [7:0] cnt_q;
  logic       active_q;
  logic       push;
  logic       pop;

`ifdef KEYPAD_BOUNCE_EN
  logic [1:0] bnc_q;
  logic       bouncing_q;
`endif

  assign push = in_valid & ready_q;
  // Popping happens only on the IDLE -> PRESS edge.
  assign pop  = (state_q == StIdle) && (count_q != 3'd0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO. ready is registered, so it stays low during reset and rises one edge after release.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_code;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q <= count_d;
      ready_q <= (count_d != 3'd4);
    end
  end

  // Press sequencer. Outputs are registered.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      key_q      <= '0;
      cnt_q      <= '0;
      active_q   <= 1'b0;
`ifdef KEYPAD_BOUNCE_EN
      bnc_q      <= '0;
      bouncing_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pop) begin
            key_q    <= mem_q[rd_ptr_q];
            cnt_q    <= HoldLoad;
            active_q <= 1'b1;
            state_q  <= StPress;
`ifdef KEYPAD_BOUNCE_EN
            bnc_q      <= 2'd0;
            bouncing_q <= 1'b1;
`endif
          end
        end
        StPress: begin
`ifdef KEYPAD_BOUNCE_EN
          if (bouncing_q) begin
            if (bnc_q == 2'd3) begin
              // The bounce is done, so reload the counter for the full steady hold.
              bouncing_q <= 1'b0;
              active_q   <= 1'b1;
              cnt_q      <= HoldLoad;
            end else begin
              // The next bounce phase is odd when the current one is even.
              bnc_q    <= bnc_q + 2'd1;
              active_q <= bnc_q[0];
            end
          end else begin
`else
          begin
`endif
            if (cnt_q == 8'd0) begin
              state_q  <= StGap;
              cnt_q    <= GapLoad;
              active_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        StGap: begin
          if (cnt_q == 8'd0) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    row = 4'b1111;
    if (active_q && !col[key_q[1:0]]) begin
      row[key_q[3:2]] = 1'b0;
    end
  end

  assign in_ready   = ready_q;
  assign active     = active_q;
  assign fifo_count = count_q;

endmodule
